uart_cmd_ctrl: RTL

- Command-frame sequencer behind the UART receive datapath (baud generator + serial-to-parallel).
- Consumes the received byte stream, frames it into commands (header, command, length, payload, checksum), and streams payload bytes to a buffer write port.
- Reports each good frame, or a coded error, to downstream control logic.
- Runs an inter-byte timeout so a broken frame can never stall the parser.

---
 rtl/uart_cmd_ctrl.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/uart_cmd_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : uart_cmd_ctrl
// Purpose  : Frames received UART bytes into commands and streams the payload
//            to a buffer write port, with an inter-byte timeout.
// Revision : 1.0
// ============================================================================
module uart_cmd_ctrl #(
    parameter logic [7:0] HEADER      = 8'hA5,
    parameter int         MAX_LEN     = 16,
    parameter int         TIMEOUT_CYC = 52083
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_rx_en,
    input  logic [7:0] i_rx_data,
    output logic       o_pl_we,
    output logic [7:0] o_pl_addr,
    output logic [7:0] o_pl_data,
    output logic       o_cmd_valid,
    output logic [7:0] o_cmd,
    output logic [7:0] o_len,
    output logic       o_err,
    output logic [1:0] o_err_code,
    output logic       o_busy,
    output logic [7:0] o_frame_cnt,
    output logic [7:0] o_err_cnt
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CMD     = 3'd1,
        S_LEN     = 3'd2,
        S_PAYLOAD = 3'd3,
        S_CSUM    = 3'd4
    } state_t;

    localparam logic [7:0]  c_MAX_LEN  = 8'(MAX_LEN);
    localparam logic [19:0] c_TMO_LAST = 20'(TIMEOUT_CYC - 1);
    localparam logic [1:0]  c_ERR_CSUM = 2'b01;
    localparam logic [1:0]  c_ERR_LEN  = 2'b10;
    localparam logic [1:0]  c_ERR_TMO  = 2'b11;

    state_t      r_state, w_state_nx;
    logic [7:0]  r_cmd_sh, r_len_sh, r_csum, r_idx;
    logic [7:0]  w_cmd_sh_nx, w_len_sh_nx, w_csum_nx, w_idx_nx;
    logic [19:0] r_tmo;
    logic        w_expire, w_pl_we, w_good, w_err;
    logic [1:0]  w_err_code;

    // A byte arriving on the expiry cycle takes priority over the timeout.
    assign w_expire = (r_state != S_IDLE) && !i_rx_en && (r_tmo == c_TMO_LAST);

    always_comb begin
        w_state_nx  = r_state;
        w_cmd_sh_nx = r_cmd_sh;
        w_len_sh_nx = r_len_sh;
        w_csum_nx   = r_csum;
        w_idx_nx    = r_idx;
        w_pl_we     = 1'b0;
        w_good      = 1'b0;
        w_err       = 1'b0;
        w_err_code  = 2'b00;
        if (i_rx_en) begin
            case (r_state)
                S_IDLE: begin
                    if (i_rx_data == HEADER) w_state_nx = S_CMD;
                end
                S_CMD: begin
                    w_cmd_sh_nx = i_rx_data;
                    w_csum_nx   = i_rx_data;
                    w_state_nx  = S_LEN;
                end
                S_LEN: begin
                    w_len_sh_nx = i_rx_data;
                    w_csum_nx   = r_csum + i_rx_data;
                    w_idx_nx    = 8'd0;
                    if (i_rx_data > c_MAX_LEN) begin
                        w_err      = 1'b1;
                        w_err_code = c_ERR_LEN;
                        w_state_nx = S_IDLE;
                    end else if (i_rx_data == 8'd0) begin
                        w_state_nx = S_CSUM;
                    end else begin
                        w_state_nx = S_PAYLOAD;
                    end
                end
                S_PAYLOAD: begin
                    w_pl_we   = 1'b1;
                    w_csum_nx = r_csum + i_rx_data;
                    w_idx_nx  = r_idx + 8'd1;
                    if (r_idx == r_len_sh - 8'd1) w_state_nx = S_CSUM;
                end
                S_CSUM: begin
                    if (i_rx_data == r_csum) begin
                        w_good = 1'b1;
                    end else begin
                        w_err      = 1'b1;
                        w_err_code = c_ERR_CSUM;
                    end
                    w_state_nx = S_IDLE;
                end
                default: w_state_nx = S_IDLE;
            endcase
        end else if (w_expire) begin
            w_err      = 1'b1;
            w_err_code = c_ERR_TMO;
            w_state_nx = S_IDLE;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_cmd_sh    <= 8'd0;
            r_len_sh    <= 8'd0;
            r_csum      <= 8'd0;
            r_idx       <= 8'd0;
            r_tmo       <= 20'd0;
            o_busy      <= 1'b0;
            o_pl_we     <= 1'b0;
            o_pl_addr   <= 8'd0;
            o_pl_data   <= 8'd0;
            o_cmd_valid <= 1'b0;
            o_cmd       <= 8'd0;
            o_len       <= 8'd0;
            o_err       <= 1'b0;
            o_err_code  <= 2'b00;
            o_frame_cnt <= 8'd0;
            o_err_cnt   <= 8'd0;
        end else begin
            r_state     <= w_state_nx;
            r_cmd_sh    <= w_cmd_sh_nx;
            r_len_sh    <= w_len_sh_nx;
            r_csum      <= w_csum_nx;
            r_idx       <= w_idx_nx;
            r_tmo       <= (i_rx_en || (w_state_nx == S_IDLE)) ? 20'd0 : r_tmo + 20'd1;
            o_busy      <= (w_state_nx != S_IDLE);
            o_pl_we     <= w_pl_we;
            o_cmd_valid <= w_good;
            o_err       <= w_err;
            if (w_pl_we) begin
                o_pl_addr <= r_idx;
                o_pl_data <= i_rx_data;
            end
            if (w_good) begin
                o_cmd       <= r_cmd_sh;
                o_len       <= r_len_sh;
                o_frame_cnt <= o_frame_cnt + 8'd1;
            end
            if (w_err) begin
                o_err_code <= w_err_code;
                if (o_err_cnt != 8'hFF) o_err_cnt <= o_err_cnt + 8'd1;
            end
        end
    end

endmodule
`default_nettype wire
